// File: rtl/apb3_interconnect_timeout.sv
// APB3 interconnect: one master, NUM_SLAVES slots decoded from a PADDR field.
// Each master transfer is re-launched as a registered SETUP/ACCESS pair, guarded by a watchdog.
module apb3_interconnect_timeout #(
  parameter int NUM_SLAVES     = 4,
  parameter int APB_DWIDTH     = 32,
  parameter int SLOT_LSB       = 12,
  parameter int SLOT_ABITS     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic [31:0]                      PADDR,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic                             PWRITE,
  input  logic [APB_DWIDTH-1:0]            PWDATA,
  output logic [APB_DWIDTH-1:0]            PRDATA,
  output logic                             PREADY,
  output logic                             PSLVERR,
  output logic [31:0]                      PADDRS,
  output logic                             PWRITES,
  output logic [APB_DWIDTH-1:0]            PWDATAS,
  output logic                             PENABLES,
  output logic [NUM_SLAVES-1:0]            PSELS,
  input  logic [NUM_SLAVES*APB_DWIDTH-1:0] PRDATAS,
  input  logic [NUM_SLAVES-1:0]            PREADYS,
  input  logic [NUM_SLAVES-1:0]            PSLVERRS,
  output logic                             TIMEOUT_EVT,
  output logic [SLOT_ABITS-1:0]            ERR_SLOT
);

  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LOAD = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [SLOT_ABITS:0] NS = (SLOT_ABITS+1)'(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, SSETUP, SACCESS, RESP} state_t;

  state_t                  state, state_nxt;
  logic [SLOT_ABITS-1:0]   slot;
  logic [SLOT_ABITS-1:0]   addr_slot;
  logic [NUM_SLAVES-1:0]   slot_onehot;
  logic [WDW-1:0]          wd_cnt;
  logic                    to_pend;
  logic                    setup_req;
  logic                    slot_hit;
  logic                    slv_ready;
  logic                    slv_err;
  logic                    wd_fire;
  logic [APB_DWIDTH-1:0]   slv_rdata;

  assign addr_slot = PADDR[SLOT_LSB +: SLOT_ABITS];
  assign setup_req = PSEL && !PENABLE;
  assign slot_hit  = ({1'b0, addr_slot} < NS);
  assign slv_ready = |(PREADYS & PSELS);
  assign slv_err   = |(PSLVERRS & PSELS);
  assign wd_fire   = WD_EN && (wd_cnt == '0) && !slv_ready;

  // PSELS is one-hot, so an AND-OR mux selects the active slot's read data
  always_comb begin
    slot_onehot = '0;
    slv_rdata   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slot_onehot[i] = (addr_slot == SLOT_ABITS'(i));
      if (PSELS[i]) slv_rdata = slv_rdata | PRDATAS[i*APB_DWIDTH +: APB_DWIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup_req) state_nxt = slot_hit ? SSETUP : RESP;
      SSETUP:  state_nxt = SACCESS;
      SACCESS: if (slv_ready || wd_fire) state_nxt = RESP;
      RESP:    if (!to_pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PRDATA      <= '0;
      PREADY      <= 1'b0;
      PSLVERR     <= 1'b0;
      PADDRS      <= '0;
      PWRITES     <= 1'b0;
      PWDATAS     <= '0;
      PENABLES    <= 1'b0;
      PSELS       <= '0;
      TIMEOUT_EVT <= 1'b0;
      ERR_SLOT    <= '0;
      slot        <= '0;
      wd_cnt      <= '0;
      to_pend     <= 1'b0;
    end else begin
      TIMEOUT_EVT <= 1'b0;
      case (state)
        IDLE: begin
          if (setup_req) begin
            PADDRS  <= PADDR;
            PWRITES <= PWRITE;
            PWDATAS <= PWDATA;
            slot    <= addr_slot;
            if (slot_hit) begin
              PSELS <= slot_onehot;
            end else begin
              PREADY   <= 1'b1;
              PSLVERR  <= 1'b1;
              PRDATA   <= '0;
              ERR_SLOT <= addr_slot;
            end
          end
        end
        SSETUP: begin
          PENABLES <= 1'b1;
          wd_cnt   <= WD_LOAD;
        end
        SACCESS: begin
          if (slv_ready) begin
            PRDATA   <= slv_rdata;
            PSLVERR  <= slv_err;
            PREADY   <= 1'b1;
            PSELS    <= '0;
            PENABLES <= 1'b0;
          end else if (wd_fire) begin
            // error response is staged here; PREADY follows one cycle after the event pulse
            PSELS       <= '0;
            PENABLES    <= 1'b0;
            PRDATA      <= '0;
            PSLVERR     <= 1'b1;
            ERR_SLOT    <= slot;
            TIMEOUT_EVT <= 1'b1;
            to_pend     <= 1'b1;
          end else if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        RESP: begin
          if (to_pend) begin
            PREADY  <= 1'b1;
            to_pend <= 1'b0;
          end else begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
